feature_accum: RTL
==================

Name: feature_accum

Overview:
- Sits directly downstream of tree_search and consumes its feature word stream (DATA_BUS_WIDTH words, FEATURE_LENTH packed DATA_WIDTH elements per octree node).
- Unpacks each node's feature words and accumulates them element-wise with signed saturating addition across all nodes of one search.
- On tree_search_done, presents one aggregated feature vector plus node count to the next stage over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, element width; signed two's complement.
- DATA_BUS_WIDTH, 64, input word width.
- FEATURE_LENTH, 9, elements per node.
- LANES, DATA_BUS_WIDTH/DATA_WIDTH (=4), elements per input word.
- WORDS_PER_NODE, ceil(FEATURE_LENTH/LANES) (=3), input words per node.
- NODE_CNT_WIDTH, 8, width of node counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- feat_in  in  DATA_BUS_WIDTH  feature word; lane j = bits [16j+15:16j].
- feat_in_valid  in  1  feat_in valid.
- feat_in_ready  out  1  block accepts feat_in this cycle.
- search_done  in  1  single-cycle pulse: end of the current search's stream.
- feat_out  out  FEATURE_LENTH*DATA_WIDTH  accumulated vector; element e = bits [16e+15:16e].
- node_cnt  out  NODE_CNT_WIDTH  complete nodes accumulated.
- partial_err  out  1  a partial node was discarded at search_done.
- feat_out_valid  out  1  result valid.
- feat_out_ready  in  1  downstream accepts result.

Behaviour:
- Reset: state=COLLECT; accumulators=0; staging=0; word_idx=0; node_cnt=0; partial_err=0; feat_out_valid=0; feat_in_ready=1. Asserting rst_n mid-operation discards everything immediately.
- Transfer rule: a word is accepted when feat_in_valid && feat_in_ready.
- COLLECT state:
  - feat_in_ready=1.
  - Accepted word at word_idx k writes its lanes to staging elements LANES*k+j.
  - Lanes whose element index is >= FEATURE_LENTH are ignored. With defaults, word 2 uses lane 0 only.
  - word_idx increments per accepted word and wraps to 0 after WORDS_PER_NODE-1.
  - On the accepting cycle of the last word, each element is updated as acc[e] <= sat(acc[e] + staging'[e]). staging' includes the lanes of the current word.
  - On that same cycle node_cnt increments, saturating at all-ones.
  - One-cycle accumulate latency; no stall between nodes.
- Saturation: compute the 17-bit signed sum. If it exceeds 32767, the result is 32767. If it is below -32768, the result is -32768.
- search_done in COLLECT:
  - Takes effect the same cycle. If a word is also accepted that cycle, the word is processed first, including completing a node.
  - If word_idx after that cycle is non-zero, the partial node is dropped (staging not added) and partial_err is set.
  - Then state -> OUTPUT and feat_out_valid is set to 1 next cycle.
  - feat_out = acc; node_cnt and partial_err hold.
- OUTPUT state:
  - feat_in_ready=0.
  - feat_out, node_cnt and partial_err are stable while feat_out_valid && !feat_out_ready.
  - On feat_out_valid && feat_out_ready: acc, staging, word_idx, node_cnt and partial_err clear; feat_out_valid=0; state -> COLLECT.
  - search_done in OUTPUT is ignored.
- Empty search (search_done with no words): result emitted with feat_out=0, node_cnt=0, partial_err=0.
- feat_out_valid is registered and does not depend combinationally on feat_out_ready. feat_in_ready is a function of state only.

Test Plan:
- 1 node: words 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, 0x0000_0000_0000_0009, then search_done -> feat_out elements 1..9, node_cnt=1, partial_err=0.
- 3 identical nodes with element0=0x7000 -> element0=0x7FFF (saturated). Same with element0=0x9000 -> 0x8000.
- 2 words of a node then search_done -> only prior full nodes summed, partial_err=1. After the result is accepted, the next search starts with word_idx=0.
- Last word of a node and search_done in the same cycle -> node included, node_cnt counts it, partial_err=0.
- feat_out_ready held low 5 cycles in OUTPUT with feat_in_valid=1 -> feat_in_ready=0, outputs stable. After the handshake, the next search starts from accumulator 0.
- Reset asserted mid-node (after 1 word) -> all outputs return to reset values asynchronously. A full node after release yields node_cnt=1 with correct sums.

Source files
------------

// File: rtl/feature_accum.sv
// feature_accum: unpacks per-node feature words from tree_search and
// accumulates them element-wise (signed, saturating) over one search, then
// hands the aggregated vector and node count downstream via valid/ready.
module feature_accum #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int FEATURE_LENTH  = 9,
  parameter int LANES          = DATA_BUS_WIDTH / DATA_WIDTH,
  parameter int WORDS_PER_NODE = (FEATURE_LENTH + LANES - 1) / LANES,
  parameter int NODE_CNT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_BUS_WIDTH-1:0]           feat_in,
  input  logic                                feat_in_valid,
  output logic                                feat_in_ready,
  input  logic                                search_done,
  output logic [FEATURE_LENTH*DATA_WIDTH-1:0] feat_out,
  output logic [NODE_CNT_WIDTH-1:0]           node_cnt,
  output logic                                partial_err,
  output logic                                feat_out_valid,
  input  logic                                feat_out_ready
);

  localparam int IDX_W = (WORDS_PER_NODE > 1) ? $clog2(WORDS_PER_NODE) : 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_e;

  state_e                                         state_q, state_d;
  logic [FEATURE_LENTH-1:0][DATA_WIDTH-1:0]       acc_q, acc_d;
  logic [FEATURE_LENTH-1:0][DATA_WIDTH-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]                               idx_q, idx_d;
  logic [NODE_CNT_WIDTH-1:0]                      cnt_q, cnt_d;
  logic                                           perr_q, perr_d;
  logic                                           accept;

  // Signed add of two elements, clamped to the representable range.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = s[DATA_WIDTH-1:0];
  endfunction

  assign feat_in_ready  = (state_q == S_COLLECT);
  assign feat_out_valid = (state_q == S_OUTPUT);
  assign feat_out       = acc_q;
  assign node_cnt       = cnt_q;
  assign partial_err    = perr_q;
  assign accept         = feat_in_valid && (state_q == S_COLLECT);

  // State and datapath registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      acc_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  // Word unpacking, node accumulation, search completion and result handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          // Staging is updated in place so the last word's lanes feed the
          // accumulate on the same cycle they arrive.
          for (int unsigned e = 0; e < FEATURE_LENTH; e++) begin
            if (idx_q == IDX_W'(e / LANES))
              stg_d[e] = feat_in[(e % LANES) * DATA_WIDTH +: DATA_WIDTH];
          end
          if (idx_q == IDX_W'(WORDS_PER_NODE - 1)) begin
            for (int unsigned e = 0; e < FEATURE_LENTH; e++)
              acc_d[e] = sat_add(acc_q[e], stg_d[e]);
            if (cnt_q != '1)
              cnt_d = cnt_q + NODE_CNT_WIDTH'(1);
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        if (search_done) begin
          if (idx_d != '0)
            perr_d = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (feat_out_ready) begin
          acc_d   = '0;
          stg_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          perr_d  = 1'b0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

endmodule
